keyboard_event_fifo: RTL and testbench
======================================

# keyboard_event_fifo

Buffers decoded keypad events between the keypad debounce stage and the CPU bus. Accepts the 16-bit one-cycle key-press pulse vector produced by the filter, serializes simultaneous presses into 4-bit key codes (lowest index first), and queues them in a DEPTH-entry FIFO. Exposes a show-ahead read port, status flags and a level interrupt to the peripheral register block, so no press is lost while software services earlier ones.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden)
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- key_pulse  input  16  one-cycle press pulses, bit i = key i; any combination may be high
- rd_en  input  1  pop head entry; ignored when empty
- clear  input  1  synchronous flush of FIFO, pending and overflow
- irq_en  input  1  interrupt enable
- rd_data  output  4  key code at FIFO head (show-ahead); 0 when empty
- empty  output  1  FIFO holds no entries
- full  output  1  count == DEPTH
- count  output  CW  number of stored entries
- overflow  output  1  sticky: a press event was lost
- irq  output  1  level interrupt, = irq_en & ~empty

## Operation
- pending[15:0] register: each edge, pending <= (pending & ~grant) | key_pulse.
- grant: one-hot of lowest set bit of pending, only when push allowed; else 0.
- Push allowed when count < DEPTH, or when rd_en & ~empty in same cycle (simultaneous push/pop at full permitted).
- Push writes encoded index of grant (0..15) at wr_ptr; wr_ptr increments, wraps at DEPTH.
- Pop (rd_en & ~empty) increments rd_ptr, wraps at DEPTH.
- count: +1 push only, -1 pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
- Re-press while pending: key_pulse[i] with pending[i]=1 and grant[i]=0 sets overflow (event merged, one lost). key_pulse[i] with grant[i]=1 leaves pending[i]=1 (new event kept), no overflow.
- FIFO full: pending bits accumulate; no push, no overflow unless a re-press per rule above.
- overflow cleared only by clear or reset.
- clear (highest priority): wr_ptr, rd_ptr, count, pending, overflow <= 0; key_pulse and rd_en in that cycle ignored; memory contents not cleared.
- rd_data = mem[rd_ptr] when ~empty, else 4'h0.
- Reset: pointers, count, pending, overflow = 0; outputs rd_data=0, empty=1, full=0, count=0, overflow=0, irq=0. Memory needs no reset.

## Timing
- key_pulse high in cycle N -> pending set after edge N -> push at edge N+1 -> empty=0, rd_data valid, irq=1 (if irq_en) in cycle N+2. Latency 2 cycles.
- k simultaneous presses enter FIFO on k consecutive edges, ascending index.
- rd_en in cycle M: new head on rd_data in cycle M+1; empty rises in M+1 if last entry.
- Flags, count, rd_data, irq are registered-state derived, no combinational path from rd_en or key_pulse.
- Throughput: one push and one pop per cycle.
- rstn asserted mid-operation: immediate return to reset values regardless of clk; queued events discarded.

## Test plan
- Reset, then key_pulse=16'h0020 for 1 cycle -> cycle N+2: empty=0, rd_data=4'h5, count=1, irq=1 (irq_en=1); rd_en 1 cycle -> empty=1, rd_data=0, irq=0.
- key_pulse=16'h0208 in one cycle -> entries 4'h3 then 4'h9 pushed on consecutive edges; count=2; pops return 3 then 9.
- DEPTH=8: press keys 0..9 one per cycle, no reads -> full=1, count=8, pending holds bits 8,9; re-press key 8 -> overflow=1; pop 8 entries -> reads 0..7, then 8 and 9 appear, count ends 2.
- Full FIFO, pending bit set, rd_en=1 every cycle -> push and pop same cycle, count stays 8, order preserved, no overflow.
- 5 entries stored, overflow=1, pending nonzero; clear=1 with key_pulse=16'h0001 same cycle -> next cycle empty=1, count=0, overflow=0, pending=0, key 0 not queued.
- Assert rstn=0 asynchronously between edges with 3 entries -> outputs at reset values immediately; after release, irq_en=0 and a press -> empty=0 but irq=0.

Source files
------------

// File: rtl/keyboard_event_fifo.sv
// Keypad event queue: serializes one-cycle key-press pulses into 4-bit key codes
// (lowest index first) and buffers them in a show-ahead FIFO for the CPU.
module keyboard_event_fifo #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [15:0]   key_pulse,
  input  logic          rd_en,
  input  logic          clear,
  input  logic          irq_en,
  output logic [3:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          irq
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   pending;
  logic [15:0]   grant;
  logic [3:0]    grant_idx;
  logic          pend_any;
  logic          pop;
  logic          push_ok;
  logic          push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign push_ok = ~full | pop;

  // Priority encoder: the scan runs high to low so the lowest set bit wins.
  always_comb begin
    grant_idx = 4'h0;
    pend_any  = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = 4'(i);
        pend_any  = 1'b1;
      end
    end
  end

  assign push  = pend_any & push_ok;
  assign grant = push ? (16'h0001 << grant_idx) : 16'h0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      // A re-press of a key that is still waiting merges into one event, losing a press.
      pending <= (pending & ~grant) | key_pulse;
      if (|(key_pulse & pending & ~grant)) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= grant_idx;
    end
  end

  assign rd_data = empty ? 4'h0 : mem[rd_ptr];
  assign irq     = irq_en & ~empty;

endmodule

// File: tb/tb_keyboard_event_fifo.sv
// Directed bench for keyboard_event_fifo: per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_keyboard_event_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rstn;
  logic [15:0]   key_pulse;
  logic          rd_en;
  logic          clear;
  logic          irq_en;
  logic [3:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          irq;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [15:0] kp;
    logic        rd;
    logic        clr;
    logic        ie;
    logic        exp_empty;
    logic        exp_full;
    int          exp_count;
    logic [3:0]  exp_rd_data;
    logic        exp_overflow;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  keyboard_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .key_pulse(key_pulse),
    .rd_en(rd_en),
    .clear(clear),
    .irq_en(irq_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags follow from the expected count; irq is modelled as irq_en & ~empty.
  function automatic void add_vec(string tag, logic [15:0] kp, logic rd, logic clr,
                                  logic ie, int cnt, logic [3:0] rdd, logic ov);
    vec_t v;
    v.tag          = tag;
    v.kp           = kp;
    v.rd           = rd;
    v.clr          = clr;
    v.ie           = ie;
    v.exp_empty    = (cnt == 0);
    v.exp_full     = (cnt == DEPTH);
    v.exp_count    = cnt;
    v.exp_rd_data  = rdd;
    v.exp_overflow = ov;
    v.exp_irq      = ie & (cnt != 0);
    vecs.push_back(v);
  endfunction

  task automatic check_output(string name, logic [15:0] actual, logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all(string tag, logic e, logic f, int cnt, logic [3:0] rdd,
                           logic ov, logic iq);
    check_output({tag, ".empty"},    16'(empty),    16'(e));
    check_output({tag, ".full"},     16'(full),     16'(f));
    check_output({tag, ".count"},    16'(count),    16'(cnt));
    check_output({tag, ".rd_data"},  16'(rd_data),  16'(rdd));
    check_output({tag, ".overflow"}, 16'(overflow), 16'(ov));
    check_output({tag, ".irq"},      16'(irq),      16'(iq));
  endtask

  task automatic apply_stimulus();
    foreach (vecs[i]) begin
      key_pulse = vecs[i].kp;
      rd_en     = vecs[i].rd;
      clear     = vecs[i].clr;
      irq_en    = vecs[i].ie;
      @(posedge clk);
      #1;
      check_all($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].exp_empty, vecs[i].exp_full,
                vecs[i].exp_count, vecs[i].exp_rd_data, vecs[i].exp_overflow,
                vecs[i].exp_irq);
    end
    key_pulse = 16'h0;
    rd_en     = 1'b0;
    clear     = 1'b0;
    vecs.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    key_pulse = 16'h0;
    rd_en     = 1'b0;
    clear     = 1'b0;
    irq_en    = 1'b1;
    #12;
    check_all("reset", 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Single press: two-cycle latency, then pop back to empty.
    add_vec("t1_press", 16'h0020, 0, 0, 1, 0, 4'h0, 0);
    add_vec("t1_push",  16'h0000, 0, 0, 1, 1, 4'h5, 0);
    add_vec("t1_pop",   16'h0000, 1, 0, 1, 0, 4'h0, 0);

    // Two simultaneous presses serialize lowest index first.
    add_vec("t2_press", 16'h0208, 0, 0, 1, 0, 4'h0, 0);
    add_vec("t2_push3", 16'h0000, 0, 0, 1, 1, 4'h3, 0);
    add_vec("t2_push9", 16'h0000, 0, 0, 1, 2, 4'h3, 0);
    add_vec("t2_pop3",  16'h0000, 1, 0, 1, 1, 4'h9, 0);
    add_vec("t2_pop9",  16'h0000, 1, 0, 1, 0, 4'h0, 0);

    // Keys 0..9 one per cycle overfill the FIFO; key 8 re-pressed while waiting.
    for (int i = 0; i < 10; i++)
      add_vec("t3_fill", 16'h0001 << i, 0, 0, 1, (i > DEPTH) ? DEPTH : i, 4'h0, 0);
    add_vec("t3_repress8", 16'h0100, 0, 0, 1, 8, 4'h0, 1);
    for (int j = 1; j <= 8; j++)
      add_vec("t3_pop", 16'h0000, 1, 0, 1, (j <= 2) ? 8 : 10 - j, 4'(j), 1);
    add_vec("t3_pop8", 16'h0000, 1, 0, 1, 1, 4'h9, 1);
    add_vec("t3_pop9", 16'h0000, 1, 0, 1, 0, 4'h0, 1);

    // Full FIFO with pending keys: pop and push together keep count at DEPTH.
    add_vec("t4_clear", 16'h0000, 0, 1, 1, 0, 4'h0, 0);
    add_vec("t4_press", 16'h0FFF, 0, 0, 1, 0, 4'h0, 0);
    for (int k = 1; k <= 8; k++)
      add_vec("t4_fill", 16'h0000, 0, 0, 1, k, 4'h0, 0);
    for (int j = 1; j <= 11; j++)
      add_vec("t4_pop", 16'h0000, 1, 0, 1, (j <= 4) ? 8 : 12 - j, 4'(j), 0);
    add_vec("t4_last", 16'h0000, 1, 0, 1, 0, 4'h0, 0);

    // Clear beats a same-cycle press and pop, and drops pending key 5.
    add_vec("t5_press", 16'h003F, 0, 0, 1, 0, 4'h0, 0);
    for (int k = 1; k <= 4; k++)
      add_vec("t5_fill", 16'h0000, 0, 0, 1, k, 4'h0, 0);
    add_vec("t5_repress5", 16'h0020, 0, 0, 1, 5, 4'h0, 1);
    add_vec("t5_clear",    16'h0001, 1, 1, 1, 0, 4'h0, 0);
    for (int k = 0; k < 3; k++)
      add_vec("t5_idle", 16'h0000, 0, 0, 1, 0, 4'h0, 0);

    add_vec("t6_press", 16'h0007, 0, 0, 1, 0, 4'h0, 0);
    for (int k = 1; k <= 3; k++)
      add_vec("t6_fill", 16'h0000, 0, 0, 1, k, 4'h0, 0);
    apply_stimulus();

    // Reset asserted between edges must act without waiting for the clock.
    #3;
    rstn = 1'b0;
    #1;
    check_all("async_reset", 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    add_vec("t6_noirq_press", 16'h0100, 0, 0, 0, 0, 4'h0, 0);
    add_vec("t6_noirq_push",  16'h0000, 0, 0, 0, 1, 4'h8, 0);
    add_vec("t6_irq_on",      16'h0000, 0, 0, 1, 1, 4'h8, 0);
    add_vec("t6_pop",         16'h0000, 1, 0, 1, 0, 4'h0, 0);
    apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
